// File: rtl/clock_divisor_if.sv
// Wishbone classic bus bundle shared by the divisor fetch master and the divisor register file.
interface clock_divisor_if;
  logic [15:0] adr;
  logic [31:0] dat_wr;
  logic [31:0] dat_rd;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport master (
    output adr, dat_wr, we, cyc, stb,
    input  dat_rd, ack
  );

  modport slave (
    input  adr, dat_wr, we, cyc, stb,
    output dat_rd, ack
  );
endinterface

// File: rtl/clock_divisor.sv
// Programmable clock divider that fetches its 32-bit divisor over Wishbone, plus the
// single-cycle-ack register file that holds the divisor half-words.
module clock_divisor #(
  parameter logic [15:0] ADDR_LO         = 16'h400A,
  parameter logic [15:0] ADDR_HI         = 16'h400B,
  parameter logic [31:0] DEFAULT_DIVISOR = 32'd4
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               sampling_clk,
  input  logic               divisor_update,
  clock_divisor_if.master    bus,
  output logic               clk_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ_LO = 2'd1;
  localparam logic [1:0] GAP     = 2'd2;
  localparam logic [1:0] READ_HI = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        pending_q, pending_d;
  logic        samp_q, upd_q;
  logic [15:0] low_q;
  logic [31:0] divisor_q;
  logic [31:0] count_q;
  logic [31:0] n_eff;
  logic        samp_rise, upd_rise, fetch_done;
  logic        unused_dat;

  assign samp_rise  = sampling_clk & ~samp_q;
  assign upd_rise   = divisor_update & ~upd_q;
  assign n_eff      = (divisor_q == 32'd0) ? 32'd1 : divisor_q;
  assign unused_dat = ^bus.dat_rd[31:16];

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    fetch_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (upd_rise || pending_q) begin
          state_d   = READ_LO;
          pending_d = 1'b0;
        end
      end
      READ_LO: begin
        if (upd_rise) pending_d = 1'b1;
        if (bus.ack)  state_d = GAP;
      end
      GAP: begin
        if (upd_rise) pending_d = 1'b1;
        state_d = READ_HI;
      end
      READ_HI: begin
        if (upd_rise) pending_d = 1'b1;
        if (bus.ack) begin
          state_d    = IDLE;
          fetch_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      samp_q    <= 1'b0;
      upd_q     <= 1'b0;
      low_q     <= 16'd0;
      divisor_q <= DEFAULT_DIVISOR;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      samp_q    <= sampling_clk;
      upd_q     <= divisor_update;
      if (state_q == READ_LO && bus.ack) low_q <= bus.dat_rd[15:0];
      if (fetch_done) divisor_q <= {bus.dat_rd[15:0], low_q};
    end
  end

  // Phase reset beats a pending wrap; a completed fetch restarts the count without toggling.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      count_q <= 32'd0;
      clk_out <= 1'b0;
    end else if (samp_rise) begin
      count_q <= 32'd0;
      clk_out <= 1'b1;
    end else if (fetch_done) begin
      count_q <= 32'd0;
    end else if (count_q == n_eff - 32'd1) begin
      count_q <= 32'd0;
      clk_out <= ~clk_out;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  assign bus.cyc    = (state_q != IDLE);
  assign bus.stb    = (state_q == READ_LO) || (state_q == READ_HI);
  assign bus.we     = 1'b0;
  assign bus.dat_wr = 32'd0;
  assign bus.adr    = (state_q == READ_LO) ? ADDR_LO :
                      (state_q == READ_HI) ? ADDR_HI : 16'd0;

endmodule

module slave_memory #(
  parameter logic [31:0] INIT_A = 32'h0000_0005,
  parameter logic [31:0] INIT_B = 32'h0000_0000
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  clock_divisor_if.slave  bus
);

  logic [31:0] mem_q [16];
  logic [31:0] dat_q;
  logic        ack_q;
  logic [3:0]  idx;
  logic        access;
  logic        unused_adr;

  assign idx        = bus.adr[3:0];
  assign unused_adr = ^bus.adr[15:4];
  // Ack pulses for one cycle, so a held strobe sees alternating ack.
  assign access     = bus.stb & bus.cyc & ~ack_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ack_q <= 1'b0;
      dat_q <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= (i == 10) ? INIT_A : (i == 11) ? INIT_B : 32'd0;
      end
    end else begin
      ack_q <= access;
      if (access) begin
        if (bus.we) mem_q[idx] <= bus.dat_wr;
        else        dat_q      <= mem_q[idx];
      end
    end
  end

  assign bus.ack    = ack_q;
  assign bus.dat_rd = dat_q;

endmodule

// File: tb/tb_clock_divisor.sv
// Directed bench for clock_divisor with slave_memory; bus addresses are checked via a scoreboard.
module tb_clock_divisor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sampling_clk = 1'b0;
  logic divisor_update = 1'b0;
  logic clk_out;

  logic        tb_own = 1'b0;
  logic [15:0] tb_adr = 16'd0;
  logic [31:0] tb_dat = 32'd0;
  logic        tb_we = 1'b0;
  logic        tb_stb = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] adr_q[$];

  logic stb_prev = 1'b0;
  int   stb_len = 0;
  int   gap_len = 0;

  always #5 clk = ~clk;

  clock_divisor_if dut_bus ();
  clock_divisor_if mem_bus ();

  // The bench borrows the slave port to preload divisor words.
  assign mem_bus.adr    = tb_own ? tb_adr : dut_bus.adr;
  assign mem_bus.dat_wr = tb_own ? tb_dat : dut_bus.dat_wr;
  assign mem_bus.we     = tb_own ? tb_we  : dut_bus.we;
  assign mem_bus.cyc    = tb_own ? tb_stb : dut_bus.cyc;
  assign mem_bus.stb    = tb_own ? tb_stb : dut_bus.stb;
  assign dut_bus.ack    = tb_own ? 1'b0 : mem_bus.ack;
  assign dut_bus.dat_rd = mem_bus.dat_rd;

  clock_divisor dut (
    .CLK_I          (clk),
    .RST_I          (rst_n),
    .sampling_clk   (sampling_clk),
    .divisor_update (divisor_update),
    .bus            (dut_bus.master),
    .clk_out        (clk_out)
  );

  slave_memory mem (
    .CLK_I (clk),
    .RST_I (rst_n),
    .bus   (mem_bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_toggle(output int n);
    logic s;
    s = clk_out;
    n = 0;
    do begin
      step();
      n++;
    end while (clk_out === s && n < 64);
    if (clk_out === s) n = -1;
  endtask

  task automatic mem_write(input logic [3:0] idx, input logic [31:0] d);
    tb_own = 1'b1; tb_adr = {12'h400, idx}; tb_dat = d; tb_we = 1'b1; tb_stb = 1'b1;
    step();
    chk("mem_write_ack", {31'd0, mem_bus.ack}, 32'd1);
    tb_stb = 1'b0; tb_we = 1'b0;
    step();
    tb_own = 1'b0;
  endtask

  task automatic mem_read(input logic [3:0] idx, input logic [31:0] exp);
    tb_own = 1'b1; tb_adr = {12'h400, idx}; tb_we = 1'b0; tb_stb = 1'b1;
    step();
    chk("mem_read_ack", {31'd0, mem_bus.ack}, 32'd1);
    chk("mem_read_dat", mem_bus.dat_rd, exp);
    tb_stb = 1'b0;
    step();
    tb_own = 1'b0;
  endtask

  task automatic pulse_update();
    divisor_update = 1'b1;
    step();
    divisor_update = 1'b0;
  endtask

  task automatic wait_fetch_done(input string tag);
    int n;
    n = 0;
    while (dut_bus.cyc === 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_period(input string tag, input int half, input int reps);
    int n;
    for (int i = 0; i < reps; i++) begin
      wait_toggle(n);
      chk(tag, n, half);
    end
  endtask

  // Bus monitor: every strobe must match the next expected address, last 2 cycles,
  // and be separated from its partner strobe by exactly one cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      stb_prev = 1'b0;
      stb_len  = 0;
      gap_len  = 0;
    end else begin
      if (dut_bus.stb && !stb_prev) begin
        if (adr_q.size() == 0) chk("unexpected_fetch", {16'd0, dut_bus.adr}, 32'hFFFF_FFFF);
        else chk("fetch_adr", {16'd0, dut_bus.adr}, {16'd0, adr_q.pop_front()});
        if (gap_len != 0) chk("gap_len", gap_len, 1);
        gap_len = 0;
        stb_len = 0;
      end
      if (!dut_bus.stb && stb_prev) chk("stb_len", stb_len, 2);
      if (dut_bus.stb)      stb_len++;
      else if (dut_bus.cyc) gap_len++;
      else                  gap_len = 0;
      stb_prev = dut_bus.stb;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc_cnt;

    // Reset state
    repeat (3) step();
    chk("rst_clk_out", {31'd0, clk_out}, 32'd0);
    chk("rst_cyc", {31'd0, dut_bus.cyc}, 32'd0);
    chk("rst_stb", {31'd0, dut_bus.stb}, 32'd0);
    chk("rst_we", {31'd0, dut_bus.we}, 32'd0);
    chk("rst_adr", {16'd0, dut_bus.adr}, 32'd0);
    chk("rst_dat", dut_bus.dat_wr, 32'd0);
    chk("rst_ack", {31'd0, mem_bus.ack}, 32'd0);

    // Default divisor 4: first toggle 4 cycles after release, then every 4
    rst_n = 1'b1;
    check_period("default_period", 4, 4);
    chk("idle_cyc", {31'd0, dut_bus.cyc}, 32'd0);

    // Phase reset mid-count
    if (clk_out === 1'b1) wait_toggle(n);
    repeat (2) step();
    sampling_clk = 1'b1;
    step();
    chk("samp_clk_out", {31'd0, clk_out}, 32'd1);
    sampling_clk = 1'b0;
    wait_toggle(n);
    chk("samp_next_toggle", n, 4);
    chk("samp_level_after", {31'd0, clk_out}, 32'd0);

    // Fetch divisor 5 from reset contents
    mem_read(4'hA, 32'h0000_0005);
    adr_q.push_back(16'h400A);
    adr_q.push_back(16'h400B);
    divisor_update = 1'b1;
    step();
    divisor_update = 1'b0;
    cyc_cnt = 0;
    while (dut_bus.cyc === 1'b1 && cyc_cnt < 40) begin
      cyc_cnt++;
      step();
    end
    chk("fetch_cyc_cycles", cyc_cnt, 5);
    check_period("div5_period", 5, 3);

    // Zero divisor behaves as 1; upper bits of each word are ignored
    mem_write(4'hA, 32'hBEEF_0000);
    mem_write(4'hB, 32'hCAFE_0000);
    adr_q.push_back(16'h400A);
    adr_q.push_back(16'h400B);
    pulse_update();
    wait_fetch_done("fetch_zero");
    check_period("div0_period", 1, 4);

    // Requests during a fetch collapse into exactly one further fetch
    mem_write(4'hA, 32'h1234_0006);
    mem_write(4'hB, 32'hABCD_0000);
    for (int i = 0; i < 4; i++) begin
      adr_q.push_back(16'h400A);
      adr_q.push_back(16'h400B);
    end
    for (int i = 0; i < 3; i++) begin
      divisor_update = 1'b1;
      step();
      divisor_update = 1'b0;
      step();
    end
    repeat (30) step();
    chk("refetch_remaining", adr_q.size(), 4);
    adr_q.delete();
    chk("refetch_idle", {31'd0, dut_bus.cyc}, 32'd0);
    wait_toggle(n);
    check_period("div6_period", 6, 2);

    // Reset during READ_HI aborts the cycle and restores the default divisor
    adr_q.push_back(16'h400A);
    adr_q.push_back(16'h400B);
    pulse_update();
    n = 0;
    while (!(dut_bus.adr === 16'h400B && mem_bus.ack === 1'b1) && n < 20) begin
      step();
      n++;
    end
    chk("reach_read_hi", {31'd0, dut_bus.stb}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cyc", {31'd0, dut_bus.cyc}, 32'd0);
    chk("abort_stb", {31'd0, dut_bus.stb}, 32'd0);
    chk("abort_ack", {31'd0, mem_bus.ack}, 32'd0);
    chk("abort_clk_out", {31'd0, clk_out}, 32'd0);
    step();
    rst_n = 1'b1;
    check_period("post_reset_period", 4, 3);
    chk("post_reset_queue", adr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_divisor.md
# clock_divisor

Programmable clock divider with a Wishbone classic master port that fetches its 32-bit divisor from a Wishbone slave on request. It generates `clk_out` from `CLK_I`, and a `sampling_clk` tick re-phases it. It is paired with `slave_memory`, a small single-cycle-ACK Wishbone slave register file holding the divisor words; this README specifies both.

## Interface
Parameters (clock_divisor):
- ADDR_LO, 16'h400A, address of the divisor low half-word
- ADDR_HI, 16'h400B, address of the divisor high half-word
- DEFAULT_DIVISOR, 32'd4, divisor used after reset

Parameters (slave_memory):
- INIT_A, 32'h0000_0005, reset content of word 0xA
- INIT_B, 32'h0000_0000, reset content of word 0xB

Ports (clock_divisor):
- CLK_I  in  1  system clock; all logic on its rising edge
- RST_I  in  1  asynchronous, active-low reset
- sampling_clk  in  1  synchronous phase-reset tick (rising edge acts)
- divisor_update  in  1  synchronous request to refetch divisor (rising edge acts)
- DAT_I  in  32  Wishbone read data
- ACK_I  in  1  Wishbone acknowledge
- DAT_O  out  32  Wishbone write data, constant 0
- WE_O  out  1  write enable, constant 0 (reads only)
- CYC_O, STB_O  out  1  Wishbone cycle/strobe
- ADR_O  out  16  Wishbone address
- clk_out  out  1  divided clock

Ports (slave_memory): CLK_I, RST_I (same rules), ADR_I[15:0], DAT_I[31:0], WE_I, STB_I, CYC_I in; DAT_O[31:0], ACK_O out.

## Operation
- Divider: 32-bit counter. Effective N = divisor, or 1 if divisor = 0. Counter increments each cycle. When counter = N-1: counter <= 0 and clk_out toggles. Period is 2N CLK_I cycles.
- sampling_clk rising edge (registered previous value = 0, current = 1): counter <= 0, clk_out <= 1. This takes priority over the wrap/toggle.
- Fetch FSM states: IDLE, READ_LO, GAP, READ_HI.
  - IDLE -> READ_LO on a divisor_update rising edge, or when the pending flag is set.
  - READ_LO: CYC=STB=1, ADR=ADDR_LO. On ACK_I, capture DAT_I[15:0] as the new low half, then go to GAP.
  - GAP: CYC=1, STB=0 for one cycle, then go to READ_HI.
  - READ_HI: CYC=STB=1, ADR=ADDR_HI. On ACK_I, divisor <= {DAT_I[15:0], low}, counter <= 0, clk_out unchanged, then go to IDLE with CYC=STB=0.
- A divisor_update rising edge outside IDLE sets the pending flag. The flag is cleared on entry to READ_LO. A fetch never aborts on a new request.
- No timeout: the master waits indefinitely for ACK_I.
- slave_memory: 16 x 32 array indexed by ADR_I[3:0].
  - ACK_O <= STB_I & CYC_I & ~ACK_O, a one-cycle registered pulse.
  - On that edge: a read loads DAT_O <= mem[idx]; a write loads mem[idx] <= DAT_I.

## Timing
- Reset (RST_I low, async) for clock_divisor: clk_out=0, counter=0, divisor=DEFAULT_DIVISOR, CYC_O=STB_O=WE_O=0, ADR_O=0, DAT_O=0, FSM=IDLE, pending=0, edge registers=0.
- Reset for slave_memory: ACK_O=0, DAT_O=0, mem = INIT_A at 0xA, INIT_B at 0xB, 0 elsewhere.
- Reset mid-fetch aborts the bus cycle immediately and reverts divisor to the default.
- Fetch latency: update edge seen at edge e; STB_O high after e; ACK_O high after e+1; low half captured at e+2; STB_O high again after e+3; ACK after e+4. The new divisor and counter clear take effect at e+5.
- DAT_O of the slave is valid in the same cycle as ACK_O.

## Test plan
- Reset release with no stimulus -> clk_out toggles every 4 cycles (period 8); CYC_O stays 0.
- sampling_clk one-cycle pulse mid-count -> next edge clk_out=1, counter=0; following toggle 4 cycles later.
- divisor_update pulse, memory 0xA=5, 0xB=0 -> ADR_O 400A then 400B, each STB held exactly 2 cycles with a 1-cycle gap; from e+5, toggle every 5 cycles.
- Memory 0xA=0x0000, 0xB=0x0000 then update -> N treated as 1; clk_out toggles every cycle.
- Second divisor_update during READ_LO -> exactly one further fetch starts after the first completes.
- RST_I asserted during READ_HI -> CYC_O/STB_O drop immediately; divisor returns to 4; slave ACK_O=0.
